fft_r4_16p_out_reorder: RTL and testbench
=========================================

// Module: fft_r4_16p_out_reorder
// PURPOSE
//  Downstream of FFT_R4_16p: captures its 4-lane parallel outputs (bf2_output_0..3, real/im)
//  over 4 beats per frame and emits the 16 bins serially in natural order (X[0]..X[15]).
//  Undoes radix-4 digit reversal; ping-pong banks allow back-to-back frames.
//  No arithmetic: IEEE-754 words are moved bit-exact.
// PARAMETERS
//  DATA_W  32  width of each real/imag word (float32 bit pattern)
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high reset
//  in_valid     in   1         beat valid; 4 lanes carried this cycle
//  in_start     in   1         qualifies beat 0 of a frame (ignored when in_valid=0)
//  in_real_0..3 in   DATA_W    lane l real part (from bf2_output_l_real)
//  in_im_0..3   in   DATA_W    lane l imag part (from bf2_output_l_im)
//  out_valid    out  1         out_real/out_im/out_index valid
//  out_ready    in   1         consumer accepts when out_valid&out_ready
//  out_real     out  DATA_W    bin real part
//  out_im       out  DATA_W    bin imag part
//  out_index    out  4         bin number k, 0..15
//  out_last     out  1         high with k=15
//  overflow     out  1         sticky: a frame was dropped (cleared only by reset)
// BEHAVIOUR
//  - Mapping: beat g (0..3), lane l holds bin k=4*l+g; stored at addr a=4*g+l.
//    Read of bin k uses a=4*(k%4)+k/4.
//  - Storage: 2 banks x 16 x {real,im}; unreset; wr_sel, rd_sel, full[1:0], beat_cnt[1:0].
//  - Write FSM: IDLE -> (in_valid&in_start) -> FILL(beat_cnt) -> after beat 3: full[wr_sel]<=1,
//    wr_sel toggles, back to IDLE. In IDLE, in_valid without in_start is ignored.
//  - in_start during FILL: partial frame discarded, beat_cnt restarts at 0, this beat is beat 0.
//  - in_valid=0 mid-frame: FILL holds, beat_cnt unchanged (gaps allowed).
//  - Bank busy: in_valid&in_start while full[wr_sel]=1 -> overflow<=1, DROP state;
//    remaining beats ignored until next in_start; banks untouched.
//  - Read: when full[rd_sel], rd_cnt walks 0..15; each output-register load advances rd_cnt.
//    After k=15 is loaded: full[rd_sel]<=0, rd_sel toggles, rd_cnt<=0.
//  - Output register loads when (!out_valid | out_ready); holds data stable while stalled.
//    out_valid deasserts only after accept with no next word.
//  - Latency: last beat (3) on cycle t -> full set t+1 -> out_valid with k=0 at t+2.
//    With out_ready=1: one bin/cycle, bins 0..15 on t+2..t+17. Next frame's k=0 follows k=15
//    with no bubble if its bank is full.
//  - Set/clear of full[] never hit the same bank in one cycle (write bank != draining bank).
//  - Reset (any cycle, mid-frame or mid-drain): out_valid=0, out_real=0, out_im=0,
//    out_index=0, out_last=0, overflow=0, full=0, wr_sel=rd_sel=0, beat_cnt=rd_cnt=0, IDLE.
//    All buffered data discarded.
// TESTING
//  1 Frame: beat g lane l real=float(4l+g), im=-float(4l+g), out_ready=1
//    -> 16 outputs, out_index 0..15, real=float(k) (k=1 -> 32'h3F800000), out_last at k=15,
//    first out_valid 2 cycles after beat 3.
//  2 Two frames back-to-back (8 consecutive beats, ready=1)
//    -> 32 contiguous outputs, frame B k=0 directly after frame A k=15; overflow=0.
//  3 out_ready toggled 1,0,0,1 pattern -> no bin lost or duplicated;
//    out_real stable while out_valid&!out_ready.
//  4 out_ready=0, three frames sent -> frames 1,2 buffered, frame 3 dropped, overflow=1;
//    release ready -> exactly 32 bins (frames 1,2).
//  5 in_start at beat 2 of a frame, then full 4-beat frame -> only second frame emitted, k order intact.
//  6 reset asserted at output k=7 -> next cycle all outputs 0, out_valid=0;
//    new frame after reset emits k=0..15 correctly.

Source files
------------

// File: rtl/fft_r4_16p_out_reorder.sv
// Output reorder buffer for the 16-point radix-4 FFT: collects 4 beats x 4 lanes into a
// ping-pong bank and streams the 16 bins serially in natural order with valid/ready.
module fft_r4_16p_out_reorder #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_start,
    input  logic [DATA_W-1:0] in_real_0,
    input  logic [DATA_W-1:0] in_real_1,
    input  logic [DATA_W-1:0] in_real_2,
    input  logic [DATA_W-1:0] in_real_3,
    input  logic [DATA_W-1:0] in_im_0,
    input  logic [DATA_W-1:0] in_im_1,
    input  logic [DATA_W-1:0] in_im_2,
    input  logic [DATA_W-1:0] in_im_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_im,
    output logic [3:0]        out_index,
    output logic              out_last,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

    wr_state_t         wr_state;
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        full;
    logic [1:0]        beat_cnt;
    logic [3:0]        rd_cnt;

    logic [DATA_W-1:0] bank_re [2][16];
    logic [DATA_W-1:0] bank_im [2][16];
    logic [DATA_W-1:0] lane_re [4];
    logic [DATA_W-1:0] lane_im [4];

    logic              wr_en;
    logic [1:0]        wr_beat;
    logic              frame_done;
    logic              rd_load;
    logic [3:0]        rd_addr;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;

    always_comb begin
        lane_re[0] = in_real_0;
        lane_re[1] = in_real_1;
        lane_re[2] = in_real_2;
        lane_re[3] = in_real_3;
        lane_im[0] = in_im_0;
        lane_im[1] = in_im_1;
        lane_im[2] = in_im_2;
        lane_im[3] = in_im_3;
    end

    // A start beat always restarts the frame at beat 0; it is only written if its bank is free.
    always_comb begin
        wr_en   = 1'b0;
        wr_beat = '0;
        if (in_valid && in_start) begin
            wr_en = !full[wr_sel];
        end else if (in_valid && wr_state == FILL) begin
            wr_en   = 1'b1;
            wr_beat = beat_cnt;
        end
        frame_done = wr_en && (wr_beat == 2'd3);
        rd_load    = full[rd_sel] && (!out_valid || out_ready);
        rd_addr    = {rd_cnt[1:0], rd_cnt[3:2]};
        full_set   = '0;
        full_clr   = '0;
        if (frame_done)
            full_set[wr_sel] = 1'b1;
        if (rd_load && rd_cnt == 4'd15)
            full_clr[rd_sel] = 1'b1;
    end

    // Beat g, lane l carries bin 4l+g and lands at address 4g+l.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned l = 0; l < 4; l++) begin
                bank_re[wr_sel][{wr_beat, 2'(l)}] <= lane_re[l];
                bank_im[wr_sel][{wr_beat, 2'(l)}] <= lane_im[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state  <= IDLE;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            full      <= '0;
            beat_cnt  <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_im    <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            full <= (full | full_set) & ~full_clr;

            if (in_valid && in_start) begin
                if (full[wr_sel]) begin
                    overflow <= 1'b1;
                    wr_state <= DROP;
                    beat_cnt <= '0;
                end else begin
                    wr_state <= FILL;
                    beat_cnt <= 2'd1;
                end
            end else if (in_valid && wr_state == FILL) begin
                beat_cnt <= beat_cnt + 2'd1;
                if (beat_cnt == 2'd3) begin
                    wr_state <= IDLE;
                    wr_sel   <= ~wr_sel;
                end
            end

            if (rd_load) begin
                out_valid <= 1'b1;
                out_real  <= bank_re[rd_sel][rd_addr];
                out_im    <= bank_im[rd_sel][rd_addr];
                out_index <= rd_cnt;
                out_last  <= (rd_cnt == 4'd15);
                rd_cnt    <= rd_cnt + 4'd1;
                if (rd_cnt == 4'd15)
                    rd_sel <= ~rd_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_r4_16p_out_reorder.sv
// Scoreboard bench for the FFT output reorder buffer: frames are built as natural-order bins,
// scattered onto lanes/beats, and the serial output is checked against the queued bins.
module tb_fft_r4_16p_out_reorder;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_start;
    logic [DW-1:0] in_real_0, in_real_1, in_real_2, in_real_3;
    logic [DW-1:0] in_im_0, in_im_1, in_im_2, in_im_3;
    logic          out_valid, out_ready, out_last, overflow;
    logic [DW-1:0] out_real, out_im;
    logic [3:0]    out_index;

    fft_r4_16p_out_reorder #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start),
        .in_real_0(in_real_0), .in_real_1(in_real_1), .in_real_2(in_real_2), .in_real_3(in_real_3),
        .in_im_0(in_im_0), .in_im_1(in_im_1), .in_im_2(in_im_2), .in_im_3(in_im_3),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_im(out_im),
        .out_index(out_index), .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    int          n_acc = 0, run = 0, max_run = 0, last_acc_cyc = -10, cyc = 0;
    int          rmode = 0, ph = 0;
    logic [31:0] fr_re[16], fr_im[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] flt(input int unsigned v);
        int unsigned e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((v >> i) != 0) e = i;
        m = (v << (23 - e)) & 32'h007FFFFF;
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        in_valid  = 1'b0;
        in_start  = 1'($urandom_range(0, 1));
        in_real_0 = $urandom; in_real_1 = $urandom; in_real_2 = $urandom; in_real_3 = $urandom;
        in_im_0   = $urandom; in_im_1   = $urandom; in_im_2   = $urandom; in_im_3   = $urandom;
    endtask

    task automatic drive_beat(input int unsigned g, input bit st);
        in_valid  = 1'b1;
        in_start  = st;
        in_real_0 = fr_re[g];      in_im_0 = fr_im[g];
        in_real_1 = fr_re[4 + g];  in_im_1 = fr_im[4 + g];
        in_real_2 = fr_re[8 + g];  in_im_2 = fr_im[8 + g];
        in_real_3 = fr_re[12 + g]; in_im_3 = fr_im[12 + g];
        tick();
        idle_in();
    endtask

    task automatic send_frame(input int unsigned gap_max, input bit push);
        for (int unsigned g = 0; g < 4; g++) begin
            if (g != 0) repeat ($urandom_range(0, gap_max)) tick();
            drive_beat(g, g == 0);
        end
        if (push)
            for (int unsigned k = 0; k < 16; k++)
                exp_q.push_back('{re: fr_re[k], im: fr_im[k], idx: 4'(k), last: (k == 15)});
    endtask

    task automatic rand_frame;
        for (int unsigned k = 0; k < 16; k++) begin
            fr_re[k] = $urandom;
            fr_im[k] = $urandom;
        end
    endtask

    task automatic ramp_frame;
        for (int unsigned k = 0; k < 16; k++) begin
            fr_re[k] = flt(k);
            fr_im[k] = flt(k) | 32'h80000000;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // At most 16 bins outstanding means at most one bank can still be occupied.
    task automatic wait_room;
        int n = 0;
        while (exp_q.size() > 16 && n < 3000) begin
            tick();
            n++;
        end
        chk("room_for_frame", 64'(exp_q.size() > 16), 64'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            last_acc_cyc = -10;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {60'd0, out_index}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q[0];
                if (!out_ready) begin
                    chk("stall_real", 64'(out_real), 64'(mon_e.re));
                    chk("stall_index", 64'(out_index), 64'(mon_e.idx));
                end else begin
                    void'(exp_q.pop_front());
                    chk("bin_real", 64'(out_real), 64'(mon_e.re));
                    chk("bin_im", 64'(out_im), 64'(mon_e.im));
                    chk("bin_index", 64'(out_index), 64'(mon_e.idx));
                    chk("bin_last", 64'(out_last), 64'(mon_e.last));
                    n_acc++;
                    if (last_acc_cyc == cyc - 1) run++;
                    else run = 1;
                    last_acc_cyc = cyc;
                    if (run > max_run) max_run = run;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({pfx, "_out_real"}, 64'(out_real), 64'd0);
        chk({pfx, "_out_im"}, 64'(out_im), 64'd0);
        chk({pfx, "_out_index"}, 64'(out_index), 64'd0);
        chk({pfx, "_out_last"}, 64'(out_last), 64'd0);
        chk({pfx, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int a, n;
        reset = 1'b1;
        idle_in();
        repeat (3) tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // Ramp frame and first-output latency
        rmode = 0;
        ramp_frame();
        chk("float_one", 64'(fr_re[1]), 64'h3F800000);
        send_frame(0, 1);
        @(negedge clk);
        chk("lat_t1_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("lat_t2_valid", 64'(out_valid), 64'd1);
        chk("lat_t2_index", 64'(out_index), 64'd0);
        tick();
        wait_drain("ramp_drain");

        // Back-to-back frames stream without a bubble
        max_run = 0;
        rand_frame(); send_frame(0, 1);
        rand_frame(); send_frame(0, 1);
        wait_drain("b2b_drain");
        chk("b2b_contiguous_run", 64'(max_run), 64'd32);
        chk("b2b_overflow", 64'(overflow), 64'd0);

        // Ready pattern 1,0,0,1
        rmode = 1;
        a = n_acc;
        rand_frame(); send_frame(1, 1);
        rand_frame(); send_frame(1, 1);
        wait_drain("pattern_drain");
        chk("pattern_count", 64'(n_acc - a), 64'd32);

        // Restart in mid-frame: only the second frame is emitted
        rmode = 0;
        a = n_acc;
        rand_frame();
        drive_beat(0, 1'b1);
        drive_beat(1, 1'b0);
        rand_frame(); send_frame(0, 1);
        wait_drain("restart_drain");
        chk("restart_count", 64'(n_acc - a), 64'd16);

        // Randomized traffic, gaps, stray non-start beats while idle
        rmode = 2;
        for (int unsigned f = 0; f < 20; f++) begin
            rand_frame();
            wait_room();
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b1;
                in_start = 1'b0;
                tick();
                idle_in();
            end
            send_frame($urandom_range(0, 2), 1);
        end
        wait_drain("random_drain");
        chk("random_overflow", 64'(overflow), 64'd0);

        // Consumer stalled: two frames buffer, third dropped
        rmode = 3;
        tick(); tick();
        a = n_acc;
        rand_frame(); send_frame(0, 1);
        rand_frame(); send_frame(0, 1);
        rand_frame(); send_frame(0, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("drop_overflow", 64'(overflow), 64'd1);
        chk("drop_stalled_valid", 64'(out_valid), 64'd1);
        rmode = 0;
        wait_drain("drop_drain");
        repeat (10) tick();
        chk("drop_count", 64'(n_acc - a), 64'd32);

        // Reset in the middle of a drain
        rand_frame(); send_frame(0, 1);
        n = 0;
        while (!(out_valid && out_index == 4'd7) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_k7", {59'd0, out_valid, out_index}, {59'd0, 1'b1, 4'd7});
        reset = 1'b1;
        tick();
        check_zero_outputs("midreset");
        exp_q.delete();
        reset = 1'b0;
        a = n_acc;
        ramp_frame(); send_frame(1, 1);
        wait_drain("post_reset_drain");
        chk("post_reset_count", 64'(n_acc - a), 64'd16);
        chk("post_reset_overflow", 64'(overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
